reg_dst_queue: RTL and testbench
================================

# reg_dst_queue

Parametrised write-destination unit for the datapath register file. It combines the destination-register select (rt, rd, rs, $ra, $sp, $zero) with an in-order queue of in-flight write destinations. The queue provides writeback-ordered destinations and read-after-write hazard flags for two read ports. It sits between the control unit's `sel` decode and the register-file write port / stall logic, and replaces the purely combinational destination mux.

## Interface
Parameters:
- `AW`, 5, register-number width
- `DEPTH`, 4, in-flight queue entries (power of two, ≥2)
- `RA_IDX`, 31, register number for the return-address select
- `SP_IDX`, 29, register number for the stack-pointer select

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset)
- `sel`  in  3  destination select
- `in_rt`, `in_rd`, `in_rs`  in  AW each  instruction register fields
- `push`  in  1  enqueue the currently selected destination
- `pop`  in  1  retire the oldest entry (writeback done)
- `rd_a`, `rd_b`  in  AW  source registers to hazard-check
- `dst`  out  AW  combinational selected destination
- `wb_dst`  out  AW  oldest queued destination
- `wb_valid`  out  1  queue non-empty
- `full`, `empty`  out  1  queue status
- `count`  out  log2(DEPTH)+1  occupancy
- `hazard_a`, `hazard_b`  out  1  source matches a queued destination
- `err`  out  1  sticky overflow/underflow flag

## Operation
- Select decode, combinational: 000 → `in_rt`; 001 → `in_rd`; 010 → `in_rs`; 011 → RA_IDX; 100 → SP_IDX; 101/110/111 → 0.
- The queue is a circular buffer with head/tail pointers (log2(DEPTH) bits, natural wrap) and a separate `count`.
- `push` && !`full`: write `dst` at tail; tail+1; count+1.
- `pop` && !`empty`: head+1; count−1. Entry contents are not cleared.
- `push` && `pop` in the same cycle, neither blocked: both happen and `count` is unchanged. This is legal when full: slot freed and refilled.
- `push` && `full` && !`pop`: push dropped; `err` set.
- `pop` && `empty`: ignored; `err` set. Simultaneous `push` still proceeds.
- `err` is sticky and clears only on reset.
- `hazard_x` = (`rd_x` ≠ 0) AND `rd_x` equals any of the `count` valid entries, counted from head. Register 0 never flags.
- `wb_dst` = entry at head and `wb_valid` = !`empty`. When empty, `wb_dst` is 0.

## Timing
- Reset: head = tail = 0, count = 0, all entries 0, `err` = 0. This gives `empty`=1, `full`=0, `wb_valid`=0, `wb_dst`=0, hazards 0. `dst` follows inputs even in reset.
- Reset overrides `push`/`pop` in the same cycle. Reset mid-operation discards all entries.
- `dst` has zero latency (combinational).
- Push at edge t: entry visible in `count`, `hazard_*`, `wb_dst` (if it was empty) from t+1. There is no same-cycle bypass: a push does not flag a hazard in its own cycle.
- Pop at edge t: the popped entry still contributes to hazards during cycle t and is removed from t+1.
- `full`, `empty`, `count`, `wb_dst`, `wb_valid`, `hazard_*` are decoded from registered state only. They have no combinational path from `push`/`pop`.

## Configuration
- `REGDST_ZERO_FILTER_EN` defined: a push whose `dst` is 0 is silently discarded. No entry is written, count is unchanged, and `err` is not set even if full. Writes to $zero never occupy the queue.
- Undefined: destination 0 is queued like any other. It still never raises a hazard and pops normally.

## Test plan
- Reset then idle: `reset`=0 for 2 cycles, then 1 → `empty`=1, `count`=0, `wb_valid`=0, `err`=0.
- Select sweep: `in_rt`=3, `in_rd`=7, `in_rs`=9, `sel` 0..7 → `dst` = 3,7,9,31,29,0,0,0.
- Fill/overflow (DEPTH=4):
  - push 4 distinct dests (5,6,8,10) → `full`=1, `count`=4, `wb_dst`=5.
  - 5th push alone → dropped, `err`=1, `count`=4.
- Hazards: queue {5,6}, `rd_a`=6, `rd_b`=0 → `hazard_a`=1, `hazard_b`=0. Pop twice → `hazard_a`=0 from the cycle after the second pop.
- Wrap plus simultaneous push/pop when full: 10 cycles of push+pop with incrementing dests → `count` stays 4 and `wb_dst` sequence is in order. Then pop on empty → `err`=1.
- Zero filter: push with `sel`=5 → `count` unchanged with `REGDST_ZERO_FILTER_EN` defined; `count`+1 without it.

Source files
------------

// File: rtl/reg_dst_queue.sv
// Write-destination select plus in-order queue of in-flight destinations with RAW hazard flags.
// Optional build macro: REGDST_ZERO_FILTER_EN (pushes of register 0 are discarded).
module reg_dst_queue #(
  parameter int AW     = 5,
  parameter int DEPTH  = 4,
  parameter int RA_IDX = 31,
  parameter int SP_IDX = 29
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               sel,
  input  logic [AW-1:0]            in_rt,
  input  logic [AW-1:0]            in_rd,
  input  logic [AW-1:0]            in_rs,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            rd_a,
  input  logic [AW-1:0]            rd_b,
  output logic [AW-1:0]            dst,
  output logic [AW-1:0]            wb_dst,
  output logic                     wb_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          err_r;

  logic [AW-1:0] dst_s;
  logic          full_s;
  logic          empty_s;
  logic          zero_drop_s;
  logic          pop_ok_s;
  logic          push_ok_s;
  logic          ovf_s;
  logic          unf_s;
  logic          hit_a_s;
  logic          hit_b_s;

  // Destination select decode; follows inputs combinationally, even in reset.
  always_comb begin
    dst_s = {AW{1'b0}};
    case (sel)
      3'b000:  dst_s = in_rt;
      3'b001:  dst_s = in_rd;
      3'b010:  dst_s = in_rs;
      3'b011:  dst_s = AW'(RA_IDX);
      3'b100:  dst_s = AW'(SP_IDX);
      default: dst_s = {AW{1'b0}};
    endcase
  end

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

`ifdef REGDST_ZERO_FILTER_EN
  assign zero_drop_s = (dst_s == {AW{1'b0}});
`else
  assign zero_drop_s = 1'b0;
`endif

  // A pop frees a slot in the same edge, so a full queue still accepts push+pop.
  assign pop_ok_s  = pop && !empty_s;
  assign push_ok_s = push && !zero_drop_s && (!full_s || pop_ok_s);
  assign ovf_s     = push && !zero_drop_s && full_s && !pop;
  assign unf_s     = pop && empty_s;

  // Associative match of both read ports against the valid entries, oldest first.
  always_comb begin
    hit_a_s = 1'b0;
    hit_b_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_a_s = hit_a_s | ((CW'(i) < count_r) && (mem_r[head_r + PW'(i)] == rd_a));
      hit_b_s = hit_b_s | ((CW'(i) < count_r) && (mem_r[head_r + PW'(i)] == rd_b));
    end
  end

  // Queue state: pointers, occupancy, storage and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      err_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {AW{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[tail_r] <= dst_s;
        tail_r        <= tail_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
      err_r   <= err_r | ovf_s | unf_s;
    end
  end

  assign dst      = dst_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign err      = err_r;
  assign wb_valid = !empty_s;
  assign wb_dst   = empty_s ? {AW{1'b0}} : mem_r[head_r];
  assign hazard_a = hit_a_s && (rd_a != {AW{1'b0}});
  assign hazard_b = hit_b_s && (rd_b != {AW{1'b0}});

endmodule

// File: tb/tb_reg_dst_queue.sv
// Self-checking bench for reg_dst_queue: directed scenarios plus randomized traffic
// compared with a queue-based reference model.
module tb_reg_dst_queue;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
`ifdef REGDST_ZERO_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    sel;
  logic [AW-1:0] in_rt, in_rd, in_rs, rd_a, rd_b;
  logic          push, pop;
  logic [AW-1:0] dst, wb_dst;
  logic          wb_valid, full, empty, hazard_a, hazard_b, err;
  logic [2:0]    count;

  int checks = 0;
  int failures = 0;

  // reference model state
  int mq[$];
  bit merr;

  reg_dst_queue #(.AW(AW), .DEPTH(DEPTH), .RA_IDX(31), .SP_IDX(29)) dut (
    .clk(clk), .reset(reset), .sel(sel), .in_rt(in_rt), .in_rd(in_rd), .in_rs(in_rs),
    .push(push), .pop(pop), .rd_a(rd_a), .rd_b(rd_b), .dst(dst), .wb_dst(wb_dst),
    .wb_valid(wb_valid), .full(full), .empty(empty), .count(count),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int exp_dst();
    case (sel)
      3'd0: return int'(in_rt);
      3'd1: return int'(in_rd);
      3'd2: return int'(in_rs);
      3'd3: return 31;
      3'd4: return 29;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_haz(input int r);
    if (r == 0) return 1'b0;
    foreach (mq[i]) if (mq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_wb();
    return (mq.size() > 0) ? mq[0] : 0;
  endfunction

  task automatic model_step();
    int d;
    bit drop, was_full, was_empty, do_pop, do_push;
    if (!reset) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      d = exp_dst();
      drop = FILT && (d == 0);
      was_full = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      do_pop = pop && !was_empty;
      do_push = push && !drop && (!was_full || do_pop);
      if (pop && was_empty) merr = 1'b1;
      if (push && !drop && was_full && !pop) merr = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; sel = 3'd0;
    in_rt = '0; in_rd = '0; in_rs = '0; rd_a = '0; rd_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push_val(input int v);
    sel = 3'd0; in_rt = AW'(v); push = 1'b1; pop = 1'b0;
    tick();
    push = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0; push = 1'b1; pop = 1'b1; sel = 3'd1; in_rd = 5'd7;
    tick(); tick();
    reset = 1'b1; push = 1'b0; pop = 1'b0; rd_a = 5'd7; rd_b = 5'd0;
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got %0b expected 0", wb_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (full !== 1'b0 || wb_dst !== 5'd0 || hazard_a !== 1'b0) begin
      failures++; $display("FAIL reset_misc: full=%0b wb_dst=%0d hazard_a=%0b expected 0/0/0", full, wb_dst, hazard_a);
    end
  endtask

  task automatic test_select();
    int tbl[8] = '{3, 7, 9, 31, 29, 0, 0, 0};
    in_rt = 5'd3; in_rd = 5'd7; in_rs = 5'd9;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      checks++; if (int'(dst) != tbl[s]) begin failures++; $display("FAIL select_%0d: got %0d expected %0d", s, dst, tbl[s]); end
    end
    sel = 3'd0;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    push_val(5); push_val(6); push_val(8); push_val(10);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full: got %0b expected 1", full); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (wb_dst !== 5'd5) begin failures++; $display("FAIL fill_wb_dst: got %0d expected 5", wb_dst); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fill_err_early: got %0b expected 0", err); end
    push_val(12);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL overflow_err: got %0b expected 1", err); end
    checks++; if (count !== 3'd4 || wb_dst !== 5'd5) begin
      failures++; $display("FAIL overflow_state: count=%0d wb_dst=%0d expected 4/5", count, wb_dst);
    end
  endtask

  task automatic test_hazards();
    do_reset();
    push_val(5); push_val(6);
    rd_a = 5'd6; rd_b = 5'd0; #1;
    checks++; if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
      failures++; $display("FAIL hazard_basic: a=%0b b=%0b expected 1/0", hazard_a, hazard_b);
    end
    rd_b = 5'd5; pop = 1'b1; #1;
    checks++; if (hazard_b !== 1'b1) begin failures++; $display("FAIL hazard_pop_cycle: got %0b expected 1", hazard_b); end
    tick();
    checks++; if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
      failures++; $display("FAIL hazard_after_pop1: a=%0b b=%0b expected 1/0", hazard_a, hazard_b);
    end
    #1;
    checks++; if (hazard_a !== 1'b1) begin failures++; $display("FAIL hazard_second_pop_cycle: got %0b expected 1", hazard_a); end
    tick();
    pop = 1'b0;
    checks++; if (hazard_a !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL hazard_after_pop2: a=%0b wb_valid=%0b expected 0/0", hazard_a, wb_valid);
    end
    push_val(7);
    rd_a = 5'd7; sel = 3'd1; in_rd = 5'd9; push = 1'b1; rd_b = 5'd9; #1;
    checks++; if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
      failures++; $display("FAIL hazard_no_bypass: a=%0b b=%0b expected 1/0", hazard_a, hazard_b);
    end
    tick();
    push = 1'b0;
    checks++; if (hazard_b !== 1'b1) begin failures++; $display("FAIL hazard_next_cycle: got %0b expected 1", hazard_b); end
  endtask

  task automatic test_wrap();
    int seq[14];
    do_reset();
    for (int i = 0; i < 4; i++) seq[i] = i + 1;
    for (int i = 0; i < 10; i++) seq[4 + i] = 11 + i;
    for (int i = 0; i < 4; i++) push_val(seq[i]);
    for (int k = 0; k < 10; k++) begin
      sel = 3'd0; in_rt = AW'(seq[4 + k]); push = 1'b1; pop = 1'b1;
      tick();
      checks++; if (count !== 3'd4 || int'(wb_dst) != seq[k + 1]) begin
        failures++; $display("FAIL wrap_%0d: count=%0d wb_dst=%0d expected 4/%0d", k, count, wb_dst, seq[k + 1]);
      end
    end
    push = 1'b0; pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (int'(wb_dst) != seq[10 + k]) begin
        failures++; $display("FAIL drain_%0d: got %0d expected %0d", k, wb_dst, seq[10 + k]);
      end
      tick();
    end
    checks++; if (err !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL drain_end: err=%0b empty=%0b expected 0/1", err, empty);
    end
    sel = 3'd1; in_rd = 5'd4; push = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL underflow_err: got %0b expected 1", err); end
    checks++; if (count !== 3'd1 || wb_dst !== 5'd4) begin
      failures++; $display("FAIL underflow_push: count=%0d wb_dst=%0d expected 1/4", count, wb_dst);
    end
  endtask

  task automatic test_zero_filter();
    do_reset();
    sel = 3'd5; push = 1'b1;
    tick();
    push = 1'b0;
    checks++; if (int'(count) != (FILT ? 0 : 1)) begin
      failures++; $display("FAIL zero_push: count=%0d expected %0d", count, FILT ? 0 : 1);
    end
    rd_a = 5'd0; #1;
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL zero_hazard: got %0b expected 0", hazard_a); end
    push_val(1); push_val(2); push_val(3); push_val(4);
    sel = 3'd6; push = 1'b1;
    tick();
    push = 1'b0;
    checks++; if (err !== merr) begin failures++; $display("FAIL zero_full_err: got %0b expected %0b", err, merr); end
  endtask

  task automatic test_random();
    int phase;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      phase = (n / 25) % 2;
      sel = 3'($urandom_range(7));
      in_rt = AW'($urandom); in_rd = AW'($urandom); in_rs = AW'($urandom);
      push = phase == 0 ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      pop  = phase == 0 ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      rd_a = (mq.size() > 0 && $urandom_range(1) == 1) ? AW'(mq[$urandom_range(mq.size() - 1)]) : AW'($urandom);
      rd_b = (mq.size() > 0 && $urandom_range(1) == 1) ? AW'(mq[$urandom_range(mq.size() - 1)]) : AW'($urandom);
      reset = ($urandom_range(60) == 0) ? 1'b0 : 1'b1;
      #1;
      checks++; if (int'(dst) != exp_dst()) begin failures++; $display("FAIL rnd_dst@%0d: got %0d expected %0d", n, dst, exp_dst()); end
      checks++; if (int'(count) != mq.size()) begin failures++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, count, mq.size()); end
      checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || wb_valid !== (mq.size() != 0)) begin
        failures++; $display("FAIL rnd_status@%0d: full=%0b empty=%0b wb_valid=%0b size=%0d", n, full, empty, wb_valid, mq.size());
      end
      checks++; if (int'(wb_dst) != exp_wb()) begin failures++; $display("FAIL rnd_wb_dst@%0d: got %0d expected %0d", n, wb_dst, exp_wb()); end
      checks++; if (hazard_a !== exp_haz(int'(rd_a)) || hazard_b !== exp_haz(int'(rd_b))) begin
        failures++; $display("FAIL rnd_hazard@%0d: a=%0b b=%0b expected %0b/%0b", n, hazard_a, hazard_b, exp_haz(int'(rd_a)), exp_haz(int'(rd_b)));
      end
      checks++; if (err !== merr) begin failures++; $display("FAIL rnd_err@%0d: got %0b expected %0b", n, err, merr); end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    merr = 1'b0;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_select();
    test_fill_overflow();
    test_hazards();
    test_wrap();
    test_zero_filter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
